// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD display controller.
// Holds the FSM state type and the double-dabble adjust step.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CONV_BITS  = 16;
  localparam int unsigned ACC_DIGITS = 5;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // One double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [4*ACC_DIGITS-1:0] dabble_adjust(input logic [4*ACC_DIGITS-1:0] acc);
    logic [4*ACC_DIGITS-1:0] r;
    r = acc;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Decimal digit to active-low 7-segment pattern (bit 6 = g).
// Non-decimal codes decode to all segments off.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (bcd_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// driving four registered digits and their 7-segment decodes.
module seg7_bcd_ctrl
  import seg7_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3
);

  localparam logic [3:0] LastIter = 4'(CONV_BITS - 1);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [CONV_BITS-1:0]    shift_q;
  logic [4*ACC_DIGITS-1:0] acc_q;
  logic [4*ACC_DIGITS-1:0] acc_adj;

  assign acc_adj     = dabble_adjust(acc_q);
  assign value_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      acc_q    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd0     <= '0;
      bcd1     <= '0;
      bcd2     <= '0;
      bcd3     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (value_valid) begin
            shift_q <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          {acc_q, shift_q} <= {acc_adj, shift_q} << 1;
          cnt_q            <= cnt_q + 4'd1;
          if (cnt_q == LastIter) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd0     <= acc_q[3:0];
          bcd1     <= acc_q[7:4];
          bcd2     <= acc_q[11:8];
          bcd3     <= acc_q[15:12];
          // A nonzero ten-thousands digit means the value exceeded 9999.
          overflow <= (acc_q[19:16] != 4'd0);
          done     <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [3:0] digit   [NUM_DIGITS];
  logic [6:0] seg_raw [NUM_DIGITS];
  logic [3:1] blank;

  assign digit[0] = bcd0;
  assign digit[1] = bcd1;
  assign digit[2] = bcd2;
  assign digit[3] = bcd3;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    seg7_lut u_lut (
      .bcd_i (digit[g]),
      .seg_o (seg_raw[g])
    );
  end

  // A digit blanks only if it and every higher digit are zero; never on overflow.
  always_comb begin
    blank = '0;
    if (BLANK_LEADING && !overflow) begin
      blank[3] = (bcd3 == 4'd0);
      blank[2] = blank[3] && (bcd2 == 4'd0);
      blank[1] = blank[2] && (bcd1 == 4'd0);
    end
  end

  assign seg0 = seg_raw[0];
  assign seg1 = blank[1] ? SEG_BLANK : seg_raw[1];
  assign seg2 = blank[2] ? SEG_BLANK : seg_raw[2];
  assign seg3 = blank[3] ? SEG_BLANK : seg_raw[3];

endmodule

// File: tb/tb_seg7_bcd_ctrl.sv
// Directed bench for seg7_bcd_ctrl: vector table plus hand-written sequences
// for back-to-back accepts, reset abort and reset/accept collision.
module tb_seg7_bcd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;

  logic       ready0, done0, ovf0;
  logic [3:0] b00, b01, b02, b03;
  logic [6:0] s00, s01, s02, s03;
  logic       ready1, done1, ovf1;
  logic [3:0] b10, b11, b12, b13;
  logic [6:0] s10, s11, s12, s13;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_bcd_ctrl #(.BLANK_LEADING(1'b0)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (ready0),
    .done        (done0),
    .overflow    (ovf0),
    .bcd0        (b00),
    .bcd1        (b01),
    .bcd2        (b02),
    .bcd3        (b03),
    .seg0        (s00),
    .seg1        (s01),
    .seg2        (s02),
    .seg3        (s03)
  );

  seg7_bcd_ctrl #(.BLANK_LEADING(1'b1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (ready1),
    .done        (done1),
    .overflow    (ovf1),
    .bcd0        (b10),
    .bcd1        (b11),
    .bcd2        (b12),
    .bcd3        (b13),
    .seg0        (s10),
    .seg1        (s11),
    .seg2        (s12),
    .seg3        (s13)
  );

  typedef struct {
    logic [15:0] value;
    logic [15:0] digits;
    logic        ovf;
    logic [27:0] seg_nb;
    logic [27:0] seg_bl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] digits0();
    return {b03, b02, b01, b00};
  endfunction

  // Accept v, wait for done, check latency, digits, overflow and both seg sets.
  task automatic convert(input vec_t v, input string tag);
    int k;
    @(negedge clk);
    chk({tag, " ready"}, 32'(ready0), 32'd1);
    value       = v.value;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    k = 0;
    while (k < 40 && !done0) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(k), 32'd17);
    chk({tag, " digits"}, 32'(digits0()), 32'(v.digits));
    chk({tag, " digits_bl"}, 32'({b13, b12, b11, b10}), 32'(v.digits));
    chk({tag, " overflow"}, 32'({ovf1, ovf0}), {30'd0, v.ovf, v.ovf});
    chk({tag, " seg_nb"}, 32'({s03, s02, s01, s00}), 32'(v.seg_nb));
    chk({tag, " seg_bl"}, 32'({s13, s12, s11, s10}), 32'(v.seg_bl));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'({done1, done0}), 32'd0);
    chk({tag, " ready_after"}, 32'({ready1, ready0}), 32'd3);
  endtask

  // value_valid held high throughout; value scrambled while busy, v2 offered once ready.
  task automatic back_to_back(input logic [15:0] v1, input logic [15:0] d1, input logic o1,
                              input logic [15:0] v2, input logic [15:0] d2, input logic o2,
                              input string tag);
    int k;
    int n_done;
    int busy_bad;
    @(negedge clk);
    value       = v1;
    value_valid = 1'b1;
    @(posedge clk);
    k        = 0;
    n_done   = 0;
    busy_bad = 0;
    @(negedge clk);
    while (k < 60 && n_done < 2) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if ((k <= 16 || (k >= 19 && k <= 34)) && ready0) busy_bad++;
      if (done0) begin
        n_done++;
        if (n_done == 1) begin
          chk({tag, " first_edge"}, 32'(k), 32'd17);
          chk({tag, " first_digits"}, 32'(digits0()), 32'(d1));
          chk({tag, " first_ovf"}, 32'(ovf0), 32'(o1));
        end else begin
          chk({tag, " second_edge"}, 32'(k), 32'd35);
          chk({tag, " second_digits"}, 32'(digits0()), 32'(d2));
          chk({tag, " second_ovf"}, 32'(ovf0), 32'(o2));
          value_valid = 1'b0;
        end
      end
      value = ready0 ? v2 : 16'(16'd5000 + 16'(k));
    end
    value_valid = 1'b0;
    chk({tag, " both_done"}, 32'(n_done), 32'd2);
    chk({tag, " busy_ready_low"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    int seen_done;
    vec_t v9999;

    vecs[0] = '{16'd1234,  16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'd65535, 16'h5535, 1'b1, {7'h12, 7'h12, 7'h30, 7'h12}, {7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[2] = '{16'd7,     16'h0007, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[3] = '{16'd0,     16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{16'd9999,  16'h9999, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{16'd10000, 16'h0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{16'd305,   16'h0305, 1'b0, {7'h40, 7'h30, 7'h40, 7'h12}, {7'h7F, 7'h30, 7'h40, 7'h12}};
    vecs[7] = '{16'd10,    16'h0010, 1'b0, {7'h40, 7'h40, 7'h79, 7'h40}, {7'h7F, 7'h7F, 7'h79, 7'h40}};
    vecs[8] = '{16'd20000, 16'h0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    v9999   = vecs[4];

    reset       = 1'b1;
    value       = 16'd0;
    value_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'({ready1, ready0}), 32'd3);
    chk("reset done", 32'({done1, done0}), 32'd0);
    chk("reset digits", 32'(digits0()), 32'd0);
    chk("reset ovf", 32'({ovf1, ovf0}), 32'd0);
    chk("reset seg_nb", 32'({s03, s02, s01, s00}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    chk("reset seg_bl", 32'({s13, s12, s11, s10}), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i], $sformatf("vec%0d", i));
    end

    back_to_back(16'd1234, 16'h1234, 1'b0, 16'd9, 16'h0009, 1'b0, "hold_valid");
    back_to_back(16'd10000, 16'h0000, 1'b1, 16'd9, 16'h0009, 1'b0, "b2b");

    // Abort: accept 4321, reset sampled on CONV edge 8.
    @(negedge clk);
    value       = 16'd4321;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort ready", 32'(ready0), 32'd1);
    seen_done = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 || done1) seen_done++;
    end
    chk("abort no_done", 32'(seen_done), 32'd0);
    chk("abort digits", 32'(digits0()), 32'd0);
    chk("abort ovf", 32'(ovf0), 32'd0);
    convert(v9999, "after_abort");

    // Reset and accept on the same edge: reset must win.
    @(negedge clk);
    reset       = 1'b1;
    value       = 16'd1234;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    value_valid = 1'b0;
    seen_done   = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) seen_done++;
    end
    chk("collide no_done", 32'(seen_done), 32'd0);
    chk("collide ready", 32'(ready0), 32'd1);
    chk("collide digits", 32'(digits0()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg7_bcd_ctrl.md
SEG7_BCD_CTRL -- requirements
Module: seg7_bcd_ctrl

Interface
REQ-001 Parameter BLANK_LEADING, default 0; when 1, leading zero digits above digit 0 are blanked.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 value  input  16  unsigned binary value to display, sampled only on accept.
REQ-005 value_valid  input  1  requester has a value to convert.
REQ-006 value_ready  output  1  block can accept a value this cycle.
REQ-007 done  output  1  single-cycle pulse; new digits are visible this cycle.
REQ-008 overflow  output  1  last accepted value exceeded 9999.
REQ-009 bcd0..bcd3  output  4 each  registered decimal digits, units to thousands.
REQ-010 seg0..seg3  output  7 each  active-low segment patterns for bcd0..bcd3 (bit 6 = g).

Function
REQ-011 The block SHALL convert binary to BCD sequentially by shift-add-3 (double dabble), one bit per clock, with no divider or modulo operator.
REQ-012 FSM states SHALL be IDLE, CONV and DONE.
REQ-013 IDLE: value_ready=1; accept occurs on an edge where value_valid=1 in IDLE.
REQ-014 On accept, the block SHALL capture value into a 16-bit shift register, clear a 20-bit (5-digit) BCD accumulator, clear a 4-bit iteration counter, and enter CONV.
REQ-015 CONV: each edge, every BCD nibble >=5 SHALL get +3, then {bcd,shift} SHALL shift left 1; after the 16th iteration the FSM SHALL enter DONE.
REQ-016 DONE: on the next edge, bcd0..bcd3 SHALL load the low four accumulator digits, overflow SHALL load (ten-thousands digit != 0 OR thousands-to-units > 9999 never occurs, i.e. value > 9999), done SHALL be 1 for the following cycle, and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be exactly 17 edges from accept to outputs updating; throughput one value per 18 cycles.
REQ-018 value_ready SHALL be 0 in CONV and DONE; value_valid there SHALL be ignored and value not sampled.
REQ-019 For value > 9999, digits SHALL show value mod 10000 and overflow SHALL be 1.
REQ-020 bcd0..bcd3 and overflow SHALL hold between updates.
REQ-021 seg outputs SHALL be combinational decode of registered bcd digits: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-022 With BLANK_LEADING=1, segN (N=3..1) SHALL be 7'h7F when digit N and all higher digits are 0 and overflow=0; seg0 is never blanked.

Reset
REQ-023 Reset SHALL set FSM=IDLE, counter=0, bcd0..bcd3=0, overflow=0, done=0, shift and accumulator=0.
REQ-024 value_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-025 Reset during CONV or DONE SHALL abort without a done pulse and without updating digits from the aborted conversion.
REQ-026 Reset SHALL take priority over an accept on the same edge.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the FSM state type, NUM_DIGITS=4, CONV_BITS=16 and SEG_BLANK=7'h7F.
REQ-028 Digit-to-segment decode SHALL be the existing SEG7_LUT, instantiated four times; no other sub-module.

Verification
REQ-029 Accept 1234 -> done 17 edges later; bcd3..0=1,2,3,4; seg3..0=79,24,30,19; overflow=0.
REQ-030 Accept 65535 -> bcd3..0=5,5,3,5; overflow=1; seg never blanked.
REQ-031 BLANK_LEADING=1, accept 7 -> seg0=78, seg1..3=7F; then accept 0 -> seg0=40, seg1..3=7F.
REQ-032 value_valid held high with changing value during CONV -> value_ready=0, only the first value converted; next accept on first IDLE cycle after done.
REQ-033 Accept 4321, assert reset at edge 8 of CONV -> no done, all digits 0, value_ready=1 next cycle; then accept 9999 -> 9,9,9,9, overflow=0.
REQ-034 Back-to-back accepts of 10000 then 9 -> first result 0,0,0,0 with overflow=1; second 0,0,0,9 with overflow=0, exactly 18 cycles apart.
